// File: rtl/vertex_fetch.sv
// Streams a vertex list out of a fixed-latency vertex memory and expands each
// xyz word into a homogeneous position (w = 1.0) for the transform stage.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing reads, one every ISSUE_INTERVAL cycles
// DRAIN | all reads issued, waiting for the last vertex to return
// DONE  | one-cycle completion pulse
module vertex_fetch #(
    parameter int ADDR_WIDTH     = 10,
    parameter int BRAM_LATENCY   = 2,
    parameter int ISSUE_INTERVAL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   vertex_count,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [95:0]           rd_data,
    output logic [31:0]           pos [3:0],
    output logic                  v_out,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam int TW = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
    localparam logic [TW-1:0]       TIMER_RELOAD = TW'(ISSUE_INTERVAL - 1);
    localparam logic [ADDR_WIDTH:0] IDX_ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [31:0]         W_ONE        = 32'h3f80_0000;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]     idx_q, idx_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BRAM_LATENCY-1:0] vld_q, vld_d;
    logic                    v_out_q, v_out_d;
    logic [95:0]             xyz_q, xyz_d;
    logic                    accept;
    logic                    last_issue;

    assign accept = (state_q == IDLE) && start;
    // The index is one bit wider than the address so a full-memory list ends without wrapping.
    assign last_issue = ((idx_q + IDX_ONE) == cnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (vertex_count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (rd_en && last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (v_out_q && (vld_q == '0)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en = (state_q == FETCH) && (timer_q == '0);
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        vld_d   = (vld_q << 1) | BRAM_LATENCY'(rd_en);
        v_out_d = vld_q[BRAM_LATENCY-1];
        xyz_d   = vld_q[BRAM_LATENCY-1] ? rd_data : xyz_q;
        if (accept) begin
            cnt_d   = vertex_count;
            idx_d   = '0;
            timer_d = '0;
        end else if (rd_en) begin
            idx_d   = idx_q + IDX_ONE;
            timer_d = TIMER_RELOAD;
            addr_d  = idx_q[ADDR_WIDTH-1:0];
        end else if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            addr_q  <= '0;
            vld_q   <= '0;
            v_out_q <= 1'b0;
            xyz_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            v_out_q <= v_out_d;
            xyz_q   <= xyz_d;
        end
    end

    // Address follows the live index on a read and holds the last issued one otherwise.
    assign rd_addr = rd_en ? idx_q[ADDR_WIDTH-1:0] : addr_q;
    assign v_out   = v_out_q;
    assign pos[3]  = xyz_q[95:64];
    assign pos[2]  = xyz_q[63:32];
    assign pos[1]  = xyz_q[31:0];
    assign pos[0]  = W_ONE;

endmodule

// File: tb/tb_vertex_fetch.sv
// Scoreboard bench for vertex_fetch: two instances (default parameters, and
// ADDR_WIDTH=3 / ISSUE_INTERVAL=4), each fed by a two-cycle memory model.
module tb_vertex_fetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;
    logic [10:0] cnt_a;
    logic [3:0]  cnt_b;
    logic        rd_en_a, rd_en_b;
    logic [9:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [95:0] rd_data_a, rd_data_b;
    logic [31:0] pos_a [3:0];
    logic [31:0] pos_b [3:0];
    logic        v_out_a, v_out_b, busy_a, busy_b, done_a, done_b;

    vertex_fetch u_a (
        .clk(clk), .rst(rst), .start(start_a), .vertex_count(cnt_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .pos(pos_a), .v_out(v_out_a), .busy(busy_a), .done(done_a)
    );

    vertex_fetch #(.ADDR_WIDTH(3), .BRAM_LATENCY(2), .ISSUE_INTERVAL(4)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .vertex_count(cnt_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .pos(pos_b), .v_out(v_out_b), .busy(busy_b), .done(done_b)
    );

    logic [95:0] mem_a [1024];
    logic [95:0] mem_b [8];
    logic [95:0] pa0 = '0, pa1 = '0, pb0 = '0, pb1 = '0;

    always @(posedge clk) begin
        if (rd_en_a) pa0 <= mem_a[rd_addr_a];
        pa1 <= pa0;
        if (rd_en_b) pb0 <= mem_b[rd_addr_b];
        pb1 <= pb0;
    end
    assign rd_data_a = pa1;
    assign rd_data_b = pb1;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int busy_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          q_rd_cyc[$];
    int          q_rd_addr[$];
    int          q_v_cyc[$];
    logic [95:0] q_v_xyz[$];
    int          q_done[$];

    task automatic check_ev(input string nm, input logic rde, input int addr,
                            input logic vo, input logic [127:0] p, input logic dn);
        int ec, ea;
        logic [95:0] ex;
        if (rde) begin
            total++;
            if (q_rd_cyc.size() == 0) begin
                bad++;
                $display("FAIL %s rd_unexpected: got cyc=%0d addr=%0d, want no read", nm, cyc, addr);
            end else begin
                ec = q_rd_cyc.pop_front();
                ea = q_rd_addr.pop_front();
                if (ec != cyc || ea != addr) begin
                    bad++;
                    $display("FAIL %s rd: got cyc=%0d addr=%0d, want cyc=%0d addr=%0d", nm, cyc, addr, ec, ea);
                end
            end
        end
        if (vo) begin
            total++;
            if (q_v_cyc.size() == 0) begin
                bad++;
                $display("FAIL %s vout_unexpected: got cyc=%0d pos=%h, want none", nm, cyc, p);
            end else begin
                ec = q_v_cyc.pop_front();
                ex = q_v_xyz.pop_front();
                if (ec != cyc || p != {ex, 32'h3f800000}) begin
                    bad++;
                    $display("FAIL %s vout: got cyc=%0d pos=%h, want cyc=%0d pos=%h", nm, cyc, p, ec, {ex, 32'h3f800000});
                end
            end
        end
        if (dn) begin
            total++;
            if (q_done.size() == 0) begin
                bad++;
                $display("FAIL %s done_unexpected: got cyc=%0d, want none", nm, cyc);
            end else begin
                ec = q_done.pop_front();
                if (ec != cyc) begin
                    bad++;
                    $display("FAIL %s done: got cyc=%0d, want cyc=%0d", nm, cyc, ec);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_ev("a", rd_en_a, int'(rd_addr_a), v_out_a,
                     {pos_a[3], pos_a[2], pos_a[1], pos_a[0]}, done_a);
            check_ev("b", rd_en_b, int'(rd_addr_b), v_out_b,
                     {pos_b[3], pos_b[2], pos_b[1], pos_b[0]}, done_b);
            busy_cnt = busy_cnt + int'(busy_a) + int'(busy_b);
        end
    end

    task automatic check_reset(input string nm, input int dut);
        logic [3:0]   ctl;
        int           addr;
        logic [127:0] p;
        if (dut == 0) begin
            ctl  = {rd_en_a, v_out_a, busy_a, done_a};
            addr = int'(rd_addr_a);
            p    = {pos_a[3], pos_a[2], pos_a[1], pos_a[0]};
        end else begin
            ctl  = {rd_en_b, v_out_b, busy_b, done_b};
            addr = int'(rd_addr_b);
            p    = {pos_b[3], pos_b[2], pos_b[1], pos_b[0]};
        end
        total++;
        if (ctl != 4'b0000) begin
            bad++;
            $display("FAIL %s ctl: got rd_en/v_out/busy/done=%b, want 0000", nm, ctl);
        end
        total++;
        if (addr != 0) begin
            bad++;
            $display("FAIL %s rd_addr: got %0d, want 0", nm, addr);
        end
        total++;
        if (p != {96'h0, 32'h3f800000}) begin
            bad++;
            $display("FAIL %s pos: got %h, want %h", nm, p, {96'h0, 32'h3f800000});
        end
    endtask

    task automatic push_list(input int dut, input int c0, input int count, input int ii);
        int t;
        for (int i = 0; i < count; i++) begin
            t = c0 + 1 + i * ii;
            q_rd_cyc.push_back(t);
            q_rd_addr.push_back(i);
            q_v_cyc.push_back(t + 3);
            if (dut == 0) q_v_xyz.push_back(mem_a[i]);
            else          q_v_xyz.push_back(mem_b[i]);
        end
        q_done.push_back((count == 0) ? c0 + 1 : c0 + 1 + (count - 1) * ii + 4);
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        int n;
        n = q_rd_cyc.size() + q_v_cyc.size() + q_done.size();
        while (n != 0 && k < 400) begin
            @(posedge clk);
            k++;
            n = q_rd_cyc.size() + q_v_cyc.size() + q_done.size();
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL %s drain: got pending=%0d, want 0", nm, n);
        end
    endtask

    task automatic run_list(input string nm, input int dut, input int count,
                            input int ii, input bit restart);
        int c0, exp_busy;
        @(posedge clk); #1;
        busy_cnt = 0;
        if (dut == 0) begin start_a = 1'b1; cnt_a = 11'(count); end
        else          begin start_b = 1'b1; cnt_b = 4'(count); end
        c0 = cyc;
        push_list(dut, c0, count, ii);
        exp_busy = (count == 0) ? 1 : (count - 1) * ii + 5;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        if (restart) begin
            @(posedge clk); #1;
            start_a = 1'b1;
            cnt_a   = 11'd2;
            @(posedge clk); #1;
            start_a = 1'b0;
        end
        wait_drain(nm);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy_cnt != exp_busy) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d, want %0d", nm, busy_cnt, exp_busy);
        end
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 1024; i++)
            mem_a[i] = {32'(i), 32'(i + 1000), 32'(i + 2000)};
        mem_a[0] = {32'h3f800000, 32'h40000000, 32'h40400000};
        mem_a[1] = {32'h40800000, 32'h40a00000, 32'h40c00000};
        mem_a[2] = {32'hbf800000, 32'h00000000, 32'h3f000000};
        for (int i = 0; i < 8; i++)
            mem_b[i] = {32'hb0000000 + 32'(i), 32'hc0000000 + 32'(i), 32'hd0000000 + 32'(i)};

        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        cnt_a = '0;
        cnt_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_a", 0);
        check_reset("reset_b", 1);
        rst = 1'b0;

        run_list("basic3", 0, 3, 1, 1'b0);
        run_list("empty", 0, 0, 1, 1'b0);
        run_list("single", 0, 1, 1, 1'b0);
        run_list("restart5", 0, 5, 1, 1'b1);

        // Abort a 4-vertex list one cycle after its second read; start during reset must not count.
        @(posedge clk); #1;
        start_a = 1'b1;
        cnt_a   = 11'd4;
        c0      = cyc;
        q_rd_cyc.push_back(c0 + 1); q_rd_addr.push_back(0);
        q_rd_cyc.push_back(c0 + 2); q_rd_addr.push_back(1);
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst     = 1'b1;
        start_a = 1'b1;
        cnt_a   = 11'd2;
        @(posedge clk); #1;
        rst     = 1'b0;
        start_a = 1'b0;
        check_reset("midrst", 0);
        repeat (10) @(posedge clk);
        #1;
        wait_drain("abort");
        check_reset("post_abort", 0);
        run_list("fresh3", 0, 3, 1, 1'b0);

        run_list("ii4_cnt2", 1, 2, 4, 1'b0);
        run_list("full8", 1, 8, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vertex_fetch.md
VERTEX_FETCH -- requirements
Module: vertex_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the vertex memory address width.
REQ-002 The block SHALL have parameter BRAM_LATENCY, default 2, giving the read latency in cycles from rd_en/rd_addr to rd_data (legal range 1..4).
REQ-003 The block SHALL have parameter ISSUE_INTERVAL, default 1, giving the minimum number of cycles between successive reads (legal range >=1).
REQ-004 The block SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-005 The block SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port: start  input  1  single-cycle request to stream a vertex list.
REQ-007 The block SHALL have port: vertex_count  input  ADDR_WIDTH+1  number of vertices to stream, sampled when start is accepted.
REQ-008 The block SHALL have port: rd_en  output  1  vertex memory read strobe.
REQ-009 The block SHALL have port: rd_addr  output  ADDR_WIDTH  vertex memory address.
REQ-010 The block SHALL have port: rd_data  input  96  vertex word: [95:64]=x, [63:32]=y, [31:0]=z, IEEE-754 single.
REQ-011 The block SHALL have port: pos  output  32 x [3:0] (unpacked)  homogeneous vertex: pos[3]=x, pos[2]=y, pos[1]=z, pos[0]=w.
REQ-012 The block SHALL have port: v_out  output  1  pos valid strobe, one cycle per vertex, feeding the transform stage v_in.
REQ-013 The block SHALL have port: busy  output  1  high from start acceptance through the done cycle.
REQ-014 The block SHALL have port: done  output  1  single-cycle pulse on list completion.

Function
REQ-015 The block SHALL implement FSM states IDLE, FETCH, DRAIN, DONE.
REQ-016 IDLE: start=1 SHALL latch vertex_count, clear the read index, and enter FETCH (count>0) or DONE (count=0).
REQ-017 start while not in IDLE SHALL be ignored, with no effect on the active list.
REQ-018 FETCH: rd_en SHALL assert for exactly one cycle every ISSUE_INTERVAL cycles, rd_addr = 0,1,...,count-1 in order, first read in the cycle after start acceptance.
REQ-019 After the read with address count-1 issues, the FSM SHALL enter DRAIN.
REQ-020 A BRAM_LATENCY-deep valid shift register SHALL track outstanding reads, and the rd_data return SHALL be registered into pos.
REQ-021 v_out for the read issued in cycle t SHALL assert in cycle t+BRAM_LATENCY+1, with pos[3:1] equal to that read's x,y,z.
REQ-022 pos[0] SHALL be 32'h3f800000 (1.0) whenever v_out=1.
REQ-023 pos SHALL hold its last value when v_out=0.
REQ-024 DRAIN SHALL exit to DONE in the cycle the last v_out asserts.
REQ-025 DONE SHALL assert done for exactly one cycle (the cycle after the last v_out) and return to IDLE; busy SHALL deassert the cycle after.
REQ-026 rd_addr SHALL hold its last value when rd_en=0.
REQ-027 vertex_count = 2^ADDR_WIDTH SHALL stream the full memory; rd_addr SHALL never wrap within a list.
REQ-028 Exactly vertex_count v_out pulses SHALL occur per accepted start.

Reset
REQ-029 While rst=1, the FSM SHALL go to IDLE and rd_en, v_out, busy, done, rd_addr, pos[3:1] SHALL be 0 and pos[0] SHALL be 32'h3f800000 at the next edge.
REQ-030 Reset mid-list SHALL abort the list: the valid pipeline is cleared and no v_out is produced from reads already in flight.
REQ-031 start asserted in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-032 Defaults, memory[0..2] = {1.0,2.0,3.0},{4.0,5.0,6.0},{-1.0,0,0.5}, count=3, start at cycle 0 -> rd_en cycles 1,2,3; v_out cycles 4,5,6; pos = {3f800000,40000000,40400000,3f800000}, {40800000,40a00000,40c00000,3f800000}, {bf800000,00000000,3f000000,3f800000}; done cycle 7; busy cycles 1-7.
REQ-033 ISSUE_INTERVAL=4, count=2 -> rd_en cycles 1,5; v_out cycles 4,8; done cycle 9.
REQ-034 count=0 start -> no rd_en, no v_out, done one cycle after start, busy high that single cycle.
REQ-035 start pulsed again during FETCH of a 5-vertex list -> exactly 5 v_out, one done, addresses 0..4 only.
REQ-036 rst asserted one cycle after the second rd_en of a 4-vertex list -> no further v_out or done, all outputs at reset values, a fresh start then streams normally from address 0.
REQ-037 ADDR_WIDTH=3, count=8 -> addresses 0..7, 8 v_out, no wrap, done once.
